// File: rtl/demux_deser8_if.sv
// Serial-in / parallel-out bus for demux_deser8. The link side (master) drives the serial
// bit, its qualifier and the frame marker; the deserializer (slave) returns the word and status.
interface demux_deser8_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH);

    logic             din;
    logic             din_valid;
    logic             sync;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             frame_err;
    logic [CW-1:0]    bit_idx;
    logic             busy;

    modport master (
        output din, din_valid, sync,
        input  dout, dout_valid, frame_err, bit_idx, busy
    );

    modport slave (
        input  din, din_valid, sync,
        output dout, dout_valid, frame_err, bit_idx, busy
    );
endinterface

// File: rtl/demux_deser8.sv
// 1:WIDTH serial demultiplexer. A select counter steers each accepted bit into a lane
// register; a full set of lanes is published as a registered word with a one-cycle valid pulse.

module demux_deser8_lane (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_we,
    input  logic i_d,
    output logic o_q
);
    // A write wins over a clear so a sync bit can restart the frame in its own lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     o_q <= 1'b0;
        else if (i_we)  o_q <= i_d;
        else if (i_clr) o_q <= 1'b0;
    end
endmodule

module demux_deser8 #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    demux_deser8_if.slave   bus
);
    localparam int            CW         = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST       = CW'(WIDTH - 1);
    localparam logic [CW-1:0] FIRST_LANE = LSB_FIRST ? CW'(0) : LAST;

    logic [CW-1:0]    r_bit_idx;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_frame_err;

    logic [WIDTH-1:0] w_lanes;
    logic [WIDTH-1:0] w_merged;
    logic [WIDTH-1:0] w_we;
    logic [CW-1:0]    w_sel;
    logic             w_done;
    logic             w_clr;

    assign w_sel  = LSB_FIRST ? r_bit_idx : (LAST - r_bit_idx);
    // A sync bit is always bit 0 of a new frame, so it can never complete one.
    assign w_done = bus.din_valid & ~bus.sync & (r_bit_idx == LAST);
    assign w_clr  = bus.sync | w_done;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_lane
            assign w_we[i] = bus.din_valid &
                             (bus.sync ? (FIRST_LANE == CW'(i))
                                       : ((w_sel == CW'(i)) & ~w_done));
            // Final bit bypasses its lane register straight into the output word.
            assign w_merged[i] = (w_sel == CW'(i)) ? bus.din : w_lanes[i];

            demux_deser8_lane u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .i_clr (w_clr),
                .i_we  (w_we[i]),
                .i_d   (bus.din),
                .o_q   (w_lanes[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_idx    <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_dout_valid <= w_done;
            r_frame_err  <= bus.sync & (r_bit_idx != '0);
            if (w_done)
                r_dout <= w_merged;
            // Power-of-2 width lets the increment wrap to 0 on completion.
            if (bus.din_valid)
                r_bit_idx <= bus.sync ? CW'(1) : r_bit_idx + CW'(1);
            else if (bus.sync)
                r_bit_idx <= '0;
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.bit_idx    = r_bit_idx;
    assign bus.busy       = (r_bit_idx != '0);
endmodule
